// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the data-side memory controller:
// access-width codes, MMIO offsets, STATUS bit layout and load/store lane helpers.
package data_mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    localparam logic [7:0] TX_OFS     = 8'h00;
    localparam logic [7:0] STATUS_OFS = 8'h08;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;

    // Narrow a little-endian 64-bit raw word to the load width, sign- or zero-extending.
    function automatic logic [63:0] load_fmt(input logic [63:0] raw, input logic [2:0] f3);
        logic [63:0] res;
        case (f3)
            LB:      res = {{56{raw[7]}}, raw[7:0]};
            LH:      res = {{48{raw[15]}}, raw[15:0]};
            LW:      res = {{32{raw[31]}}, raw[31:0]};
            LD:      res = raw;
            LBU:     res = {56'd0, raw[7:0]};
            LHU:     res = {48'd0, raw[15:0]};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    // Byte-lane enables for a store of the given width; 1xx codes write nothing.
    function automatic logic [7:0] store_lanes(input logic [2:0] f3);
        logic [7:0] res;
        case (f3)
            SB:      res = 8'h01;
            SH:      res = 8'h03;
            SW:      res = 8'h0F;
            SD:      res = 8'hFF;
            default: res = 8'h00;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the console TX port.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic       o_full,
    output logic       o_empty,
    output logic [7:0] o_head
);
    localparam int PW = $clog2(DEPTH);

    logic [7:0]  r_buf [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == (PW+1)'(0));
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = o_empty ? 8'h00 : r_buf[r_rd_ptr];

    // Storage array; contents are don't-care outside the occupied window.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {(PW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: byte-addressable RAM with RV64 load/store widths
// plus an MMIO window holding the console TX FIFO and its STATUS register.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int          MEM_BYTES  = 4096,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [63:0] MMIO_BASE  = 64'hFFFF_FFFF_FFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic [63:0] rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_overflow
);
    localparam int AW = $clog2(MEM_BYTES);

    logic [7:0]    r_mem [MEM_BYTES] = '{default: 8'h00};
    logic [AW-1:0] w_lane_idx [8];
    logic [7:0]    w_lane_en;
    logic [63:0]   w_ram_word;
    logic [63:0]   w_status_word;
    logic [63:0]   w_mmio_word;
    logic [63:0]   w_src_word;
    logic          w_is_mmio;
    logic          w_store;
    logic          w_ram_we;
    logic          w_tx_store;
    logic          w_status_store;
    logic          w_full;
    logic          w_empty;
    logic          r_tx_overflow;

    assign w_is_mmio      = (addr[63:8] == MMIO_BASE[63:8]);
    assign w_store        = mem_write && !funct3[2];
    assign w_ram_we       = w_store && !w_is_mmio;
    assign w_tx_store     = w_store && w_is_mmio && (addr[7:0] == TX_OFS);
    assign w_status_store = w_store && w_is_mmio && (addr[7:0] == STATUS_OFS);
    assign w_lane_en      = w_ram_we ? store_lanes(funct3) : 8'h00;

    // Gather eight consecutive bytes; the index wraps modulo the RAM size.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_lane_idx[k]         = addr[AW-1:0] + AW'(k);
            w_ram_word[8*k +: 8]  = r_mem[w_lane_idx[k]];
        end
    end

    // MMIO read mux: only STATUS returns data, every other offset reads zero.
    always_comb begin
        w_status_word                   = 64'd0;
        w_status_word[STATUS_EMPTY_BIT] = w_empty;
        w_status_word[STATUS_FULL_BIT]  = w_full;
        w_status_word[STATUS_OVF_BIT]   = r_tx_overflow;
        if (addr[7:0] == STATUS_OFS) begin
            w_mmio_word = w_status_word;
        end else begin
            w_mmio_word = 64'd0;
        end
    end

    assign w_src_word = w_is_mmio ? w_mmio_word : w_ram_word;
    assign rdata      = mem_read ? load_fmt(w_src_word, funct3) : 64'd0;

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (w_lane_en[k]) begin
                r_mem[w_lane_idx[k]] <= wdata[8*k +: 8];
            end
        end
    end

    // Sticky overflow: a TX store dropped because the FIFO was full with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_overflow <= 1'b0;
        end else if (w_status_store) begin
            r_tx_overflow <= 1'b0;
        end else if (w_tx_store && w_full && !tx_ready) begin
            r_tx_overflow <= 1'b1;
        end else begin
            r_tx_overflow <= r_tx_overflow;
        end
    end

    tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_tx_store),
        .i_data  (wdata[7:0]),
        .i_pop   (tx_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (tx_data)
    );

    assign tx_valid    = !w_empty;
    assign tx_overflow = r_tx_overflow;

endmodule
